// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared types and default widths for the APB request arbiter
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    localparam int APB_ADDR_W = 10;
    localparam int APB_DATA_W = 32;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant search starting after the last winner
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_idx_i,
    input  logic               enable_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o
);

    always_comb begin
        int   cand;
        logic found;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = 0;
        // Offsets 1..NUM_REQ visit every requester once, the previous winner last.
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = (int'(last_idx_i) + off) % NUM_REQ;
            if (enable_i && !found && req_i[cand]) begin
                found             = 1'b1;
                grant_o[cand]     = 1'b1;
                grant_idx_o       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - shares one APB slave port between NUM_REQ valid/ready requesters
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0]        req_write_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic [ADDR_W-1:0]         paddr_o,
    output logic                      pwrite_o,
    output logic [DATA_W-1:0]         pwdata_o,
    input  logic [DATA_W-1:0]         prdata_i,
    input  logic                      pready_i
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                arb_en;
    logic                timeout_hit;

    // Gating with reset keeps req_ready low while reset is held, even though IDLE.
    assign arb_en = (state_q == IDLE) && reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i       (req_valid_i),
        .last_idx_i  (last_q),
        .enable_i    (arb_en),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign timeout_hit = (state_q == ACCESS) && !pready_i
                         && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    addr_d  = req_addr_i[int'(grant_idx)*ADDR_W +: ADDR_W];
                    write_d = req_write_i[grant_idx];
                    wdata_d = req_wdata_i[int'(grant_idx)*DATA_W +: DATA_W];
                    last_d  = grant_idx;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                // pready wins over the timeout when both land on the last allowed cycle.
                if (pready_i) begin
                    state_d             = IDLE;
                    rsp_valid_d[last_q] = 1'b1;
                    rsp_rdata_d         = write_q ? '0 : prdata_i;
                    rsp_err_d           = 1'b0;
                end else if (timeout_hit) begin
                    state_d             = IDLE;
                    rsp_valid_d[last_q] = 1'b1;
                    rsp_rdata_d         = '0;
                    rsp_err_d           = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_q      <= IDX_W'(NUM_REQ - 1);
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready_o = grant;
    assign psel_o      = (state_q != IDLE);
    assign penable_o   = (state_q == ACCESS);
    assign paddr_o     = addr_q;
    assign pwrite_o    = write_q;
    assign pwdata_o    = wdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

    a_setup_then_access: assert property (@(posedge clk) disable iff (!reset)
        (psel_o && !penable_o) |=> (psel_o && penable_o));

    a_access_held: assert property (@(posedge clk) disable iff (!reset)
        (psel_o && penable_o && !pready_i && !timeout_hit) |=>
        (psel_o && penable_o && $stable(paddr_o) && $stable(pwrite_o) && $stable(pwdata_o)));

    a_enable_needs_sel: assert property (@(posedge clk) disable iff (!reset)
        penable_o |-> psel_o);

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - scoreboard bench for apb_req_arbiter with a randomized APB slave
module tb_apb_req_arbiter;

    localparam int N  = 2;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int T  = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rv [N];
    logic [AW-1:0] ra [N];
    logic          rw [N];
    logic [DW-1:0] rd [N];

    logic [N-1:0]    req_valid_i, req_write_i, req_ready_o, rsp_valid_o;
    logic [N*AW-1:0] req_addr_i;
    logic [N*DW-1:0] req_wdata_i;
    logic [DW-1:0]   rsp_rdata_o, pwdata_o;
    logic [DW-1:0]   prdata_i = '0;
    logic [AW-1:0]   paddr_o;
    logic            rsp_err_o, psel_o, penable_o, pwrite_o;
    logic            pready_i = 1'b0;

    always_comb begin
        req_valid_i = '0;
        req_write_i = '0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        for (int k = 0; k < N; k++) begin
            req_valid_i[k]         = rv[k];
            req_write_i[k]         = rw[k];
            req_addr_i[k*AW +: AW] = ra[k];
            req_wdata_i[k*DW +: DW] = rd[k];
        end
    end

    apb_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_write_i (req_write_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .paddr_o     (paddr_o),
        .pwrite_o    (pwrite_o),
        .pwdata_o    (pwdata_o),
        .prdata_i    (prdata_i),
        .pready_i    (pready_i)
    );

    typedef struct { int owner; logic [DW-1:0] rdata; logic err; int cyc; } rsp_t;
    typedef struct { logic [AW-1:0] addr; logic wr; logic [DW-1:0] data; } apb_t;

    rsp_t          exp_q [$];
    apb_t          apb_q [$];
    int            wq [$];
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] smem [int];
    int            last_g = N - 1;
    int            free_cyc = 0;
    int            force_w = -1;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rand_wait();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) return r % 4;
        if (r == 7) return T - 1;
        return T + $urandom_range(0, 3);
    endfunction

    // Reference model: decides the grant, the slave wait count and the expected response at acceptance.
    always @(negedge clk) begin : accept_model
        logic [N-1:0] er;
        int   g, k, ww, lat;
        rsp_t e;
        apb_t t;
        if (!reset) begin
            last_g   = N - 1;
            free_cyc = 0;
            exp_q.delete();
            apb_q.delete();
            wq.delete();
        end else begin
            er = '0;
            g  = -1;
            if (cyc >= free_cyc) begin
                for (int off = 1; off <= N; off++) begin
                    k = (last_g + off) % N;
                    if (g < 0 && rv[k]) g = k;
                end
            end
            if (g >= 0) er[g] = 1'b1;
            chk(req_ready_o == er, "req_ready", req_ready_o, er);
            if (g >= 0) begin
                ww      = (force_w >= 0) ? force_w : rand_wait();
                lat     = 3 + ((ww < T) ? ww : T - 1);
                e.owner = g;
                e.cyc   = cyc + lat;
                e.err   = (ww >= T);
                if (e.err) begin
                    e.rdata = '0;
                end else if (rw[g]) begin
                    e.rdata = '0;
                    ref_mem[int'(ra[g])] = rd[g];
                end else begin
                    e.rdata = ref_mem.exists(int'(ra[g])) ? ref_mem[int'(ra[g])] : '0;
                end
                exp_q.push_back(e);
                t.addr = ra[g];
                t.wr   = rw[g];
                t.data = rd[g];
                apb_q.push_back(t);
                wq.push_back(ww);
                last_g   = g;
                free_cyc = cyc + lat;
            end
        end
    end

    logic [DW-1:0] held_rd;
    logic          held_er;

    always @(negedge clk) begin : rsp_monitor
        rsp_t e;
        logic [N-1:0] eo;
        if (!reset) begin
            held_rd = '0;
            held_er = 1'b0;
        end else begin
            if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                chk(1'b0, "rsp_missing", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (rsp_valid_o != '0) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "rsp_unexpected", rsp_valid_o, 0);
                end else begin
                    e  = exp_q.pop_front();
                    eo = '0;
                    eo[e.owner] = 1'b1;
                    chk(rsp_valid_o == eo, "rsp_owner", rsp_valid_o, eo);
                    chk(rsp_rdata_o == e.rdata, "rsp_rdata", rsp_rdata_o, e.rdata);
                    chk(rsp_err_o == e.err, "rsp_err", rsp_err_o, e.err);
                    chk(cyc == e.cyc, "rsp_latency", cyc, e.cyc);
                    chk(!psel_o, "psel_gap", psel_o, 0);
                    held_rd = e.rdata;
                    held_er = e.err;
                end
            end else begin
                chk(rsp_rdata_o == held_rd, "rsp_rdata_hold", rsp_rdata_o, held_rd);
                chk(rsp_err_o == held_er, "rsp_err_hold", rsp_err_o, held_er);
            end
        end
    end

    logic [AW-1:0] s_addr;
    logic          s_wr;
    logic [DW-1:0] s_data;
    int            cur_w = 0;
    int            acc_n = 0;

    // APB slave: inserts cur_w wait states, drives random pready/prdata whenever it is ignored.
    always @(negedge clk) begin : apb_slave
        apb_t t;
        if (reset && psel_o && !penable_o) begin
            if (wq.size() == 0 || apb_q.size() == 0) begin
                chk(1'b0, "apb_setup_unexpected", paddr_o, 0);
                cur_w = 0;
            end else begin
                cur_w = wq.pop_front();
                t     = apb_q.pop_front();
                chk(paddr_o == t.addr, "apb_paddr", paddr_o, t.addr);
                chk(pwrite_o == t.wr, "apb_pwrite", pwrite_o, t.wr);
                if (t.wr) chk(pwdata_o == t.data, "apb_pwdata", pwdata_o, t.data);
            end
            s_addr   = paddr_o;
            s_wr     = pwrite_o;
            s_data   = pwdata_o;
            acc_n    = 0;
            pready_i = 1'($urandom_range(0, 1));
            prdata_i = $urandom;
        end else if (reset && psel_o && penable_o) begin
            chk(paddr_o == s_addr && pwrite_o == s_wr && pwdata_o == s_data,
                "apb_access_hold", paddr_o, s_addr);
            if (acc_n == cur_w) begin
                pready_i = 1'b1;
                if (s_wr) begin
                    smem[int'(s_addr)] = s_data;
                    prdata_i = $urandom;
                end else begin
                    prdata_i = smem.exists(int'(s_addr)) ? smem[int'(s_addr)] : '0;
                end
            end else begin
                pready_i = 1'b0;
                prdata_i = $urandom;
            end
            acc_n++;
        end else begin
            pready_i = 1'($urandom_range(0, 1));
            prdata_i = $urandom;
        end
    end

    task automatic issue(input int k, input logic [AW-1:0] ad, input logic wr,
                         input logic [DW-1:0] dt, input int idle);
        bit got;
        got = 1'b0;
        repeat (idle) begin
            @(posedge clk);
            #1;
        end
        ra[k] = ad;
        rw[k] = wr;
        rd[k] = dt;
        rv[k] = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (req_ready_o[k]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk(1'b0, "accept_timeout", k, 1);
        @(posedge clk);
        #1;
        rv[k] = 1'b0;
    endtask

    task automatic run_rand(input int k, input int count);
        for (int i = 0; i < count; i++)
            issue(k, AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom,
                  $urandom_range(0, 3));
    endtask

    task automatic drain();
        for (int n = 0; n < 500; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            rv[k] = 1'b0;
            ra[k] = '0;
            rw[k] = 1'b0;
            rd[k] = '0;
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk(psel_o == 1'b0, "reset_psel", psel_o, 0);
        chk(penable_o == 1'b0, "reset_penable", penable_o, 0);
        chk(req_ready_o == '0, "reset_req_ready", req_ready_o, 0);
        chk(rsp_valid_o == '0, "reset_rsp_valid", rsp_valid_o, 0);
        chk(rsp_rdata_o == '0 && rsp_err_o == 1'b0, "reset_rsp_data", rsp_rdata_o, 0);
        chk(paddr_o == '0 && pwrite_o == 1'b0 && pwdata_o == '0, "reset_apb_bus", paddr_o, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        force_w = 0;
        fork
            issue(0, 10'h007, 1'b1, 32'h12345678, 0);
            issue(1, 10'h007, 1'b0, 32'h0, 0);
        join
        fork
            for (int i = 0; i < 4; i++) issue(0, AW'(8 + i), 1'b1, $urandom, 0);
            for (int i = 0; i < 4; i++) issue(1, AW'(8 + i), 1'b0, 32'h0, 0);
        join

        issue(0, 10'h003, 1'b1, 32'hDEADBEEF, 0);
        issue(1, 10'h003, 1'b0, 32'h0, 0);

        force_w = 3;
        issue(0, 10'h009, 1'b1, 32'hA5A55A5A, 0);
        issue(1, 10'h009, 1'b0, 32'h0, 0);

        force_w = T;
        issue(1, 10'h004, 1'b1, 32'hCAFEF00D, 0);
        force_w = 0;
        issue(0, 10'h004, 1'b0, 32'h0, 0);
        force_w = T - 1;
        issue(1, 10'h003, 1'b0, 32'h0, 0);
        force_w = T + 3;
        issue(0, 10'h007, 1'b0, 32'h0, 0);
        force_w = 0;
        issue(1, 10'h007, 1'b0, 32'h0, 0);
        drain();

        force_w = 10;
        issue(0, 10'h003, 1'b0, 32'h0, 0);
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk(psel_o == 1'b0, "midreset_psel", psel_o, 0);
        chk(penable_o == 1'b0, "midreset_penable", penable_o, 0);
        chk(req_ready_o == '0, "midreset_req_ready", req_ready_o, 0);
        chk(rsp_valid_o == '0, "midreset_rsp_valid", rsp_valid_o, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        force_w = 0;
        fork
            issue(1, 10'h003, 1'b0, 32'h0, 0);
            issue(0, 10'h003, 1'b1, 32'h0BADF00D, 0);
        join
        drain();

        force_w = -1;
        fork
            run_rand(0, 25);
            run_rand(1, 25);
        join
        drain();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares one APB slave port (psel/penable/paddr/pwrite/pwdata/prdata/pready) between NUM_REQ independent requesters.
- Per-requester valid/ready request channel; round-robin grant.
- Sequences the APB SETUP → ACCESS phases; waits on pready with a bounded timeout; returns a one-cycle response (read data and error flag) to the granted requester.
- Sits between bus-master clients and the memory-mapped APB slave.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 10, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 16, max ACCESS cycles waiting for pready before error termination (≥2)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid_i  in  NUM_REQ  request valid per requester
- req_ready_o  out  NUM_REQ  request accepted this cycle, one-hot or zero
- req_addr_i  in  NUM_REQ*ADDR_W  packed addresses; requester k at slice k
- req_write_i  in  NUM_REQ  1 = write, 0 = read
- req_wdata_i  in  NUM_REQ*DATA_W  packed write data
- rsp_valid_o  out  NUM_REQ  one-cycle response pulse to the owning requester
- rsp_rdata_o  out  DATA_W  read data, valid with rsp_valid_o
- rsp_err_o  out  1  timeout error, valid with rsp_valid_o
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- paddr_o  out  ADDR_W  APB address
- pwrite_o  out  1  APB direction
- pwdata_o  out  DATA_W  APB write data
- prdata_i  in  DATA_W  APB read data
- pready_i  in  1  APB ready

Behaviour:
- Reset (reset=0, async):
  - FSM → IDLE.
  - All outputs 0.
  - Last-grant pointer = NUM_REQ-1, so requester 0 has first priority.
  - Timeout counter = 0.
  - Any in-flight transfer is abandoned; no response is issued.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid_i is set, pick grant g = first set bit searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - req_ready_o[g]=1 combinationally in this cycle only.
  - At the clock edge: latch addr/write/wdata of g, set last_grant=g, go to SETUP.
  - Requesters hold valid and payload stable until ready; valid may not be withdrawn.
- SETUP (exactly 1 cycle):
  - psel_o=1, penable_o=0; paddr/pwrite/pwdata driven from latched values.
  - Next state ACCESS; timeout counter cleared.
- ACCESS:
  - psel_o=1, penable_o=1; address, control and data held stable.
  - Each cycle with pready_i=0 increments the counter.
  - pready_i=1:
    - Transfer completes at that edge.
    - Capture prdata_i for reads; rsp_rdata=0 for writes.
    - rsp_err=0; go to IDLE.
  - Counter reaches TIMEOUT-1 with pready_i=0:
    - Terminate; go to IDLE.
    - rsp_err=1, rsp_rdata=0.
    - A late pready is ignored.
- Response:
  - Registered. rsp_valid_o[g]=1 for exactly the first IDLE cycle after ACCESS ends.
  - rsp_rdata_o and rsp_err_o are held until the next response; rsp_valid_o is 0 otherwise.
- Back-to-back operation:
  - IDLE may accept a new request in the same cycle the previous response is pulsed.
  - psel_o drops for at least that one IDLE cycle.
- Latency: acceptance edge → response pulse is min 3 cycles with zero wait states, plus one cycle per wait state.
- APB protocol rules (hold as assertions):
  - psel && !penable implies penable next cycle.
  - psel && penable && !pready implies psel && penable next cycle, unless the timeout fires.
  - penable never high without psel.
- Fairness: with all requesters valid continuously, grants rotate 0,1,…,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 transfers.
- Simultaneous events:
  - A new req_valid during SETUP/ACCESS is not acknowledged until IDLE.
  - pready_i during IDLE/SETUP is ignored.

Decomposition:
- Package apb_arb_pkg: state enum type (IDLE, SETUP, ACCESS); default width constants ADDR_W=10, DATA_W=32.
- Sub-module rr_arbiter: parameter NUM_REQ; inputs req vector, last-grant index, enable; outputs one-hot grant and encoded index. Purely combinational search with wrap.
- The top level holds the FSM, latches, timeout counter and response registers.

Test Plan:
- Single write: req0 writes addr 0x003, data 0xDEADBEEF; slave pready immediate → psel 1 cycle before penable; penable 1 cycle; rsp_valid_o=2'b01 three cycles after acceptance; rsp_err=0.
- Read-back: req1 reads 0x003 → rsp_valid_o=2'b10, rsp_rdata_o=0xDEADBEEF.
- Contention: req0 and req1 valid in the same cycle right after reset (req0 writes 0x007/0x12345678, req1 reads 0x007) → req0 granted first, then req1; req1 reads 0x12345678; steady contention alternates grants 0,1,0,1.
- Wait states: slave holds pready low for 3 ACCESS cycles → psel/penable/paddr/pwdata stable throughout; response 6 cycles after acceptance.
- Timeout: pready never asserted → ACCESS lasts TIMEOUT=16 cycles; then rsp_err_o=1, rsp_rdata_o=0; the next request is served normally.
- Reset mid-ACCESS: assert reset low during wait state → psel_o/penable_o/req_ready_o/rsp_valid_o go 0 immediately (no clock); after release, requester 0 has priority and no stale response is issued.
